// File: rtl/hp_bar_writer_pkg.sv
// Shared definitions for the screen-RAM HUD writers: RAM geometry, FSM encoding
// and default health-bar placement.
package hp_bar_writer_pkg;

  localparam int SCR_RAM_AW = 11;
  localparam int SCR_RAM_DW = 8;

  localparam logic [SCR_RAM_AW-1:0] DEF_BASE_ADDR = 11'd0;
  localparam int DEF_ROW_STRIDE = 8;
  localparam int DEF_BAR_BYTES  = 8;
  localparam int DEF_BAR_ROWS   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DRAW = 2'd2,
    ST_FIN  = 2'd3
  } bar_state_t;

  // Divider width that holds hp*W without overflow for a W-pixel bar.
  function automatic int div_bits(input int w);
    return 8 + $clog2(w + 1);
  endfunction

endpackage

// File: rtl/hp_bar_writer_if.sv
// Health-bar writer bus: hp/maxhp in, RAM write port plus busy/done status out.
interface hp_bar_writer_if;
  import hp_bar_writer_pkg::*;

  logic [7:0]            hp;
  logic [7:0]            maxhp;
  logic                  wr_en;
  logic [SCR_RAM_AW-1:0] wr_addr;
  logic [SCR_RAM_DW-1:0] wr_data;
  logic                  busy;
  logic                  done;

  modport master (
    input  hp, maxhp,
    output wr_en, wr_addr, wr_data, busy, done
  );

  modport slave (
    output hp, maxhp,
    input  wr_en, wr_addr, wr_data, busy, done
  );

endinterface

// File: rtl/hp_bar_writer_seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, N clocks from start to done.
// The first bit is resolved on the start edge; the quotient holds until the next start.
module seq_divider #(
  parameter int N = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_quotient
);

  localparam int CW = $clog2(N);

  if (N < 2) begin : g_bad_width
    $error("seq_divider needs N >= 2");
  end

  logic [N-1:0]  r_rem;
  logic [N-1:0]  r_quo;
  logic [N-1:0]  r_div;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;

  // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
  function automatic logic [2*N-1:0] div_step(input logic [N-1:0] rem,
                                               input logic [N-1:0] quo,
                                               input logic [N-1:0] dsr);
    logic [N:0] trial;
    logic       q_bit;
    trial = {rem, quo[N-1]};
    q_bit = (trial >= {1'b0, dsr});
    if (q_bit) trial = trial - {1'b0, dsr};
    return {trial[N-1:0], quo[N-2:0], q_bit};
  endfunction

  // NOTE: every register here uses <= so each flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        {r_rem, r_quo} <= div_step('0, i_dividend, i_divisor);
        r_div          <= i_divisor;
        r_cnt          <= CW'(N - 1);
        r_busy         <= 1'b1;
      end else if (r_busy) begin
        {r_rem, r_quo} <= div_step(r_rem, r_quo, r_div);
        r_cnt          <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_quotient = r_quo;

endmodule

// File: rtl/hp_bar_writer.sv
// Renders a hp/maxhp health bar into the 2048x8 screen RAM, one byte write per clock,
// redrawing the whole bar whenever hp or maxhp differs from the last drawn snapshot.
module hp_bar_writer
  import hp_bar_writer_pkg::*;
#(
  parameter logic [SCR_RAM_AW-1:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter int                    ROW_STRIDE = DEF_ROW_STRIDE,
  parameter int                    BAR_BYTES  = DEF_BAR_BYTES,
  parameter int                    BAR_ROWS   = DEF_BAR_ROWS
) (
  input  logic             clk,
  input  logic             rst,
  hp_bar_writer_if.master  bus
);

  localparam int W        = BAR_BYTES * 8;
  localparam int DIV_BITS = div_bits(W);
  localparam int BW       = (BAR_BYTES > 1) ? $clog2(BAR_BYTES) : 1;
  localparam int RW       = (BAR_ROWS > 1) ? $clog2(BAR_ROWS) : 1;

  if ((int'(BASE_ADDR) + (BAR_ROWS - 1) * ROW_STRIDE + BAR_BYTES - 1 > 2047) || (W > 128))
  begin : g_bad_geometry
    $error("hp_bar_writer: bar does not fit the screen RAM or is wider than 128 pixels");
  end

  bar_state_t            r_state;
  bar_state_t            w_state_nxt;
  logic                  r_snap_valid;
  logic [7:0]            r_snap_hp;
  logic [7:0]            r_snap_maxhp;
  logic [BW-1:0]         r_byte;
  logic [RW-1:0]         r_row;
  logic [SCR_RAM_AW-1:0] r_row_base;
  logic [BW-1:0]         w_byte_nxt;
  logic [RW-1:0]         w_row_nxt;
  logic [SCR_RAM_AW-1:0] w_base_nxt;
  logic                  w_change;
  logic                  w_div_start;
  logic                  w_div_busy;
  logic                  w_div_done;
  logic [DIV_BITS-1:0]   w_quot;
  logic [DIV_BITS-1:0]   w_fill;
  logic                  r_wr_en;
  logic [SCR_RAM_AW-1:0] r_wr_addr;
  logic [SCR_RAM_DW-1:0] r_wr_data;
  logic                  r_busy;
  logic                  r_done;

  seq_divider #(.N(DIV_BITS)) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_dividend (DIV_BITS'(bus.hp) * DIV_BITS'(W)),
    .i_divisor  (DIV_BITS'(bus.maxhp)),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_quot)
  );

  // Byte b of every bar row: bit (7-k) lit when pixel 8*b+k lies left of the fill edge.
  function automatic logic [SCR_RAM_DW-1:0] bar_byte(input logic [DIV_BITS-1:0] fill,
                                                     input logic [BW-1:0]       b);
    logic [SCR_RAM_DW-1:0] d;
    d = '0;
    for (int k = 0; k < 8; k++) d[7-k] = (DIV_BITS'({b, 3'(k)}) < fill);
    return d;
  endfunction

  assign w_change = !r_snap_valid || (bus.hp != r_snap_hp) || (bus.maxhp != r_snap_maxhp);

  always_comb begin
    w_fill = w_quot;
    if (r_snap_maxhp == 8'd0 || r_snap_hp == 8'd0) w_fill = '0;
    else if (r_snap_hp >= r_snap_maxhp)           w_fill = DIV_BITS'(W);
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_byte_nxt  = r_byte;
    w_row_nxt   = r_row;
    w_base_nxt  = r_row_base;
    w_div_start = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_change && !w_div_busy) begin
          w_div_start = 1'b1;
          w_state_nxt = ST_DIV;
        end
      end
      ST_DIV: begin
        if (w_div_done) begin
          w_state_nxt = ST_DRAW;
          w_byte_nxt  = '0;
          w_row_nxt   = '0;
          w_base_nxt  = BASE_ADDR;
        end
      end
      ST_DRAW: begin
        if (r_byte == BW'(BAR_BYTES - 1)) begin
          if (r_row == RW'(BAR_ROWS - 1)) begin
            w_state_nxt = ST_FIN;
          end else begin
            w_byte_nxt = '0;
            w_row_nxt  = r_row + RW'(1);
            w_base_nxt = r_row_base + SCR_RAM_AW'(ROW_STRIDE);
          end
        end else begin
          w_byte_nxt = r_byte + BW'(1);
        end
      end
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so the write on the bus matches the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_snap_valid <= 1'b0;
      r_snap_hp    <= '0;
      r_snap_maxhp <= '0;
      r_byte       <= '0;
      r_row        <= '0;
      r_row_base   <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte     <= w_byte_nxt;
      r_row      <= w_row_nxt;
      r_row_base <= w_base_nxt;
      if (w_div_start) begin
        r_snap_valid <= 1'b1;
        r_snap_hp    <= bus.hp;
        r_snap_maxhp <= bus.maxhp;
      end
      r_wr_en   <= (w_state_nxt == ST_DRAW);
      r_wr_addr <= (w_state_nxt == ST_DRAW) ? w_base_nxt + SCR_RAM_AW'(w_byte_nxt) : '0;
      r_wr_data <= (w_state_nxt == ST_DRAW) ? bar_byte(w_fill, w_byte_nxt) : '0;
      r_busy    <= (w_state_nxt == ST_DIV) || (w_state_nxt == ST_DRAW);
      r_done    <= (w_state_nxt == ST_FIN);
    end
  end

  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

endmodule
